// File: rtl/hamming_enc_serial.sv
// rtl/hamming_enc_serial.sv - Hamming(IP_BIT+4, IP_BIT) encoder with optional error injection and bit-serial output
module hamming_enc_serial #(
    parameter int IP_BIT = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [IP_BIT-1:0] in_data,
    input  logic [3:0]        in_inj_pos,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_bit,
    output logic              out_last,
    output logic [IP_BIT+3:0] out_code
);

    localparam int         N    = IP_BIT + 4;
    localparam logic [3:0] LAST = 4'(N - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t         r_state, w_state_nxt;
    logic [N-1:0]   r_shift, w_shift_nxt;
    logic [N-1:0]   r_pend,  w_pend_nxt;
    logic           r_pend_full, w_pend_full_nxt;
    logic [3:0]     r_cnt,   w_cnt_nxt;
    logic [N-1:0]   w_enc;
    logic           w_accept;
    logic           w_out_hs;
    logic           w_last_hs;
    logic           w_shift_free;

    // Encode the offered word: place data bits, derive the four even-parity bits, then apply injection
    always_comb begin
        logic [N-1:0]      v_code;
        logic [IP_BIT-1:0] v_d;
        logic              v_p;
        v_code = '0;
        v_d    = in_data;
        v_p    = 1'b0;
        for (int j = 1; j <= N; j++) begin
            if ((j & (j - 1)) != 0) begin
                v_code[N-j] = v_d[IP_BIT-1];
                v_d         = v_d << 1;
            end
        end
        for (int k = 0; k < 4; k++) begin
            v_p = 1'b0;
            for (int j = 1; j <= N; j++) begin
                if ((((j >> k) & 1) == 1) && ((j & (j - 1)) != 0)) begin
                    v_p = v_p ^ v_code[N-j];
                end
            end
            v_code[N-(1<<k)] = v_p;
        end
        // Positions above N (and 0) never match, so they leave the word untouched
        for (int j = 1; j <= N; j++) begin
            if (int'(in_inj_pos) == j) begin
                v_code[N-j] = ~v_code[N-j];
            end
        end
        w_enc = v_code;
    end

    assign in_ready     = ~r_pend_full;
    assign w_accept     = in_valid & ~r_pend_full;
    assign w_out_hs     = (r_state == SHIFT) & out_ready;
    assign w_last_hs    = w_out_hs & (r_cnt == LAST);
    assign w_shift_free = (r_state == IDLE) | (w_last_hs & ~r_pend_full);

    // Next-state: refill the shifter from pending or input on the last bit, otherwise advance or park
    always_comb begin
        w_state_nxt     = r_state;
        w_shift_nxt     = r_shift;
        w_pend_nxt      = r_pend;
        w_pend_full_nxt = r_pend_full;
        w_cnt_nxt       = r_cnt;
        if (w_last_hs && r_pend_full) begin
            w_shift_nxt     = r_pend;
            w_pend_full_nxt = 1'b0;
            w_cnt_nxt       = 4'd0;
            w_state_nxt     = SHIFT;
        end else if (w_accept && w_shift_free) begin
            w_shift_nxt = w_enc;
            w_cnt_nxt   = 4'd0;
            w_state_nxt = SHIFT;
        end else begin
            if (w_accept) begin
                w_pend_nxt      = w_enc;
                w_pend_full_nxt = 1'b1;
            end
            // cnt stays at LAST in IDLE so out_bit keeps showing the final code bit
            if (w_last_hs) begin
                w_state_nxt = IDLE;
            end else if (w_out_hs) begin
                w_cnt_nxt = r_cnt + 4'd1;
            end
        end
    end

    // State register with asynchronous reset; a partially sent word is dropped
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_shift     <= '0;
            r_pend      <= '0;
            r_pend_full <= 1'b0;
            r_cnt       <= 4'd0;
        end else begin
            r_state     <= w_state_nxt;
            r_shift     <= w_shift_nxt;
            r_pend      <= w_pend_nxt;
            r_pend_full <= w_pend_full_nxt;
            r_cnt       <= w_cnt_nxt;
        end
    end

    assign out_valid = (r_state == SHIFT);
    assign out_last  = (r_state == SHIFT) & (r_cnt == LAST);
    assign out_bit   = r_shift[LAST-r_cnt];
    assign out_code  = r_shift;

endmodule
